// File: rtl/exp_golomb_ctrl_pkg.sv
// rtl/exp_golomb_ctrl_pkg.sv - shared state encoding, widths and helpers for the Exp-Golomb sequencer
package exp_golomb_ctrl_pkg;

  localparam int WIN_W = 16;
  localparam int LEN_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DETECT   = 3'd1,
    ST_WAIT_PFX = 3'd2,
    ST_SUFFIX   = 3'd3,
    ST_DONE     = 3'd4
  } eg_state_e;

  // Top n bits of the window, right-aligned and zero-extended (n = 0 yields 0).
  function automatic logic [WIN_W-1:0] top_bits(input logic [WIN_W-1:0] w, input logic [3:0] n);
    return w >> (5'd16 - {1'b0, n});
  endfunction

endpackage

// File: rtl/exp_golomb_map.sv
// rtl/exp_golomb_map.sv - codeNum arithmetic and optional se(v) mapping
// EG_SE_EN compiles in the signed mapping; without it the output is always codeNum.
module exp_golomb_map
  import exp_golomb_ctrl_pkg::*;
(
  input  logic [3:0]       l_i,
  input  logic [WIN_W-1:0] suffix_i,
  input  logic             se_i,
  output logic [WIN_W-1:0] value_o
);

  logic [16:0] code_num;

  assign code_num = (17'd1 << l_i) - 17'd1 + {1'b0, suffix_i};

`ifdef EG_SE_EN
  logic [15:0] half;

  // k>>1 fits 16 bits; odd k rounds up, even k negates.
  assign half = code_num[16:1];

  always_comb begin
    value_o = code_num[15:0];
    if (se_i) begin
      if (code_num[0]) begin
        value_o = half + 16'd1;
      end else begin
        value_o = 16'd0 - half;
      end
    end
  end
`else
  logic unused_map;

  assign unused_map = se_i ^ code_num[16];
  assign value_o    = code_num[15:0];
`endif

endmodule

// File: rtl/exp_golomb_ctrl.sv
// rtl/exp_golomb_ctrl.sv - Exp-Golomb ue(v)/se(v) parse sequencer driving detector and buffer shifts
// EG_SE_EN enables the se(v) signed mapping; otherwise value is always codeNum.
module exp_golomb_ctrl
  import exp_golomb_ctrl_pkg::*;
#(
  parameter int MAX_PREFIX = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             se_mode,
  input  logic [WIN_W-1:0] BitStream_buffer_output,
  input  logic             buffer_valid,
  input  logic [3:0]       heading_one_pos,
  output logic             heading_one_en,
  output logic             shift_req,
  output logic [LEN_W-1:0] shift_len,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIN_W-1:0] value
);

  eg_state_e        state_q, state_d;
  logic             se_q, se_d;
  logic             err_q, err_d;
  logic [3:0]       l_q, l_d;
  logic [WIN_W-1:0] value_q, value_d;
  logic [WIN_W-1:0] suffix;
  logic [WIN_W-1:0] map_value;
  logic             window_zero;
  logic             prefix_too_long;

  assign suffix          = top_bits(BitStream_buffer_output, l_q);
  assign window_zero     = (BitStream_buffer_output == '0);
  assign prefix_too_long = ({1'b0, heading_one_pos} > 5'(MAX_PREFIX));

  exp_golomb_map u_map (
    .l_i      (l_q),
    .suffix_i (suffix),
    .se_i     (se_q),
    .value_o  (map_value)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      se_q    <= 1'b0;
      err_q   <= 1'b0;
      l_q     <= 4'd0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      se_q    <= se_d;
      err_q   <= err_d;
      l_q     <= l_d;
      value_q <= value_d;
    end
  end

  // Shift requests use the detector result in the same DETECT cycle.
  always_comb begin
    state_d        = state_q;
    se_d           = se_q;
    err_d          = err_q;
    l_d            = l_q;
    value_d        = value_q;
    shift_req      = 1'b0;
    shift_len      = '0;
    heading_one_en = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          se_d    = se_mode;
          err_d   = 1'b0;
          state_d = ST_DETECT;
        end
      end
      ST_DETECT: begin
        heading_one_en = 1'b0;
        if (buffer_valid) begin
          shift_req = 1'b1;
          if (window_zero) begin
            shift_len = 5'd16;
            err_d     = 1'b1;
            value_d   = '0;
            state_d   = ST_DONE;
          end else if (prefix_too_long || heading_one_pos == 4'd0) begin
            shift_len = {1'b0, heading_one_pos} + 5'd1;
            err_d     = prefix_too_long;
            value_d   = '0;
            state_d   = ST_DONE;
          end else begin
            shift_len = {1'b0, heading_one_pos} + 5'd1;
            l_d       = heading_one_pos;
            state_d   = ST_WAIT_PFX;
          end
        end
      end
      // The buffer may still show a stale valid right after the prefix shift.
      ST_WAIT_PFX: state_d = ST_SUFFIX;
      ST_SUFFIX: begin
        if (buffer_valid) begin
          shift_req = 1'b1;
          shift_len = {1'b0, l_q};
          value_d   = map_value;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign error = done & err_q;
  assign value = value_q;

endmodule

// File: tb/tb_exp_golomb_ctrl.sv
// tb/tb_exp_golomb_ctrl.sv - self-checking bench for exp_golomb_ctrl with a bitstream model
module tb_exp_golomb_ctrl;

  localparam int MAXP = 15;
  localparam int MASK = 65535;

  logic        clk = 1'b0;
  logic        reset_n, start, se_mode, buffer_valid;
  logic [15:0] win;
  logic [3:0]  pos;
  logic        heading_one_en, shift_req, busy, done, error;
  logic [4:0]  shift_len;
  logic [15:0] value;

  logic        start8, se8, valid8;
  logic [15:0] win8;
  logic [3:0]  pos8;
  logic        hoe8, req8, busy8, done8, err8;
  logic [4:0]  len8;
  logic [15:0] value8;

  always #5 clk = ~clk;

  exp_golomb_ctrl #(.MAX_PREFIX(MAXP)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .se_mode(se_mode),
    .BitStream_buffer_output(win), .buffer_valid(buffer_valid), .heading_one_pos(pos),
    .heading_one_en(heading_one_en), .shift_req(shift_req), .shift_len(shift_len),
    .busy(busy), .done(done), .error(error), .value(value)
  );

  exp_golomb_ctrl #(.MAX_PREFIX(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .se_mode(se8),
    .BitStream_buffer_output(win8), .buffer_valid(valid8), .heading_one_pos(pos8),
    .heading_one_en(hoe8), .shift_req(req8), .shift_len(len8),
    .busy(busy8), .done(done8), .error(err8), .value(value8)
  );

  bit sbits [65536];
  int ptr, pend;
  int n_cmp, n_bad, cyc;

  int q_shift[$];
  int m_val, m_err, last_val;
  bit m_busy, detecting, wait_one, sfx, done_now;
  int accept_cyc, done_cyc, done_val, done_err;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] win_at(input int p);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[15-i] = sbits[(p + i) & MASK];
    return w;
  endfunction

  function automatic int lz(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) if (w[i]) return 15 - i;
    return 16;
  endfunction

  function automatic int se_map(input int k, input bit se_eff);
    if (se_eff) return (k % 2 == 1) ? (k + 1) / 2 : -(k / 2);
    return k;
  endfunction

  // Reference decode of one element straight from the bitstream.
  task automatic decode(input int p, input bit se_eff);
    logic [15:0] w;
    int L, s, k;
    w = win_at(p);
    q_shift.delete();
    L = lz(w);
    if (w == 16'd0) begin
      q_shift.push_back(16); m_err = 1; m_val = 0;
    end else if (L > MAXP) begin
      q_shift.push_back(L + 1); m_err = 1; m_val = 0;
    end else if (L == 0) begin
      q_shift.push_back(1); m_err = 0; m_val = 0;
    end else begin
      s = 0;
      for (int i = 0; i < L; i++) s = s * 2 + int'(sbits[(p + L + 1 + i) & MASK]);
      k = (1 << L) - 1 + s;
      q_shift.push_back(L + 1);
      q_shift.push_back(L);
      m_err = 0;
      m_val = se_map(k, se_eff) & 16'hFFFF;
    end
  endtask

  task automatic check();
    bit exp_req, was_busy, se_eff;
    int exp_len;
    cyc++;
    exp_req = (detecting || sfx) && buffer_valid;
    exp_len = (exp_req && q_shift.size() > 0) ? q_shift[0] : 0;
    cmp("busy", busy, m_busy);
    cmp("hoe_en", heading_one_en, !detecting);
    cmp("done", done, done_now);
    cmp("error", error, done_now ? m_err : 0);
    cmp("shift_req", shift_req, exp_req);
    cmp("shift_len", shift_len, exp_len);
    cmp("value", value, done_now ? m_val : last_val);
    pend = shift_req ? int'(shift_len) : 0;
    if (done === 1'b1) begin
      done_cyc = cyc; done_val = value; done_err = error;
    end
    was_busy = m_busy;
    if (done_now) begin
      last_val = m_val; m_busy = 0; done_now = 0;
    end else if (detecting && buffer_valid) begin
      detecting = 0;
      if (q_shift.size() > 0) void'(q_shift.pop_front());
      if (q_shift.size() == 0) done_now = 1; else wait_one = 1;
    end else if (wait_one) begin
      wait_one = 0; sfx = 1;
    end else if (sfx && buffer_valid) begin
      sfx = 0;
      if (q_shift.size() > 0) void'(q_shift.pop_front());
      done_now = 1;
    end
    if (!was_busy && start) begin
`ifdef EG_SE_EN
      se_eff = se_mode;
`else
      se_eff = 1'b0;
`endif
      decode(ptr + pend, se_eff);
      detecting = 1; m_busy = 1; accept_cyc = cyc;
    end
  endtask

  task automatic drive_window();
    win = win_at(ptr);
    pos = (win == 16'd0) ? 4'($urandom) : 4'(lz(win));
  endtask

  task automatic tick();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
    ptr = (ptr + pend) & MASK;
    pend = 0;
    drive_window();
  endtask

  task automatic put(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) sbits[(ptr + i) & MASK] = v[n-1-i];
    drive_window();
  endtask

  task automatic run_elem(input bit se, output int lat);
    done_cyc = -1;
    start = 1'b1; se_mode = se; buffer_valid = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done_cyc >= 0) break;
      tick();
    end
    if (done_cyc < 0) cmp("done_timeout", 0, 1);
    lat = done_cyc - accept_cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, p0, wp, L, r;
    n_cmp = 0; n_bad = 0; cyc = 0; ptr = 0; pend = 0;
    m_busy = 0; detecting = 0; wait_one = 0; sfx = 0; done_now = 0; last_val = 0;
    m_val = 0; m_err = 0;
    wp = 0;
    while (wp < 65000) begin
      r = $urandom_range(0, 15);
      if (r == 0) begin
        for (int i = 0; i < 17; i++) sbits[(wp + i) & MASK] = 1'b0;
        wp += 17;
      end else begin
        L = $urandom_range(0, (r < 5) ? 15 : 4);
        for (int i = 0; i < L; i++) sbits[(wp + i) & MASK] = 1'b0;
        sbits[(wp + L) & MASK] = 1'b1;
        for (int i = 0; i < L; i++) sbits[(wp + L + 1 + i) & MASK] = 1'($urandom);
        wp += 2 * L + 1;
      end
    end
    reset_n = 1'b0; start = 1'b0; se_mode = 1'b0; buffer_valid = 1'b1;
    start8 = 1'b0; se8 = 1'b0; valid8 = 1'b0; win8 = 16'h0; pos8 = 4'd0;
    drive_window();
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // ue 1 -> codeNum 0
    put(32'b1, 1); p0 = ptr;
    run_elem(1'b0, lat);
    cmp("t1_lat", lat, 2); cmp("t1_val", done_val, 0); cmp("t1_err", done_err, 0); cmp("t1_adv", ptr - p0, 1);

    // ue 00110 -> 5
    put(32'b00110, 5); p0 = ptr;
    run_elem(1'b0, lat);
    cmp("t2_lat", lat, 4); cmp("t2_val", done_val, 5); cmp("t2_adv", ptr - p0, 5);

    // se codeNum 4 -> -2, codeNum 3 -> 2
    put(32'b00101, 5);
    run_elem(1'b1, lat);
`ifdef EG_SE_EN
    cmp("t3_val", done_val, 16'hFFFE);
`else
    cmp("t3_val", done_val, 4);
`endif
    put(32'b00100, 5);
    run_elem(1'b1, lat);
`ifdef EG_SE_EN
    cmp("t4_val", done_val, 2);
`else
    cmp("t4_val", done_val, 3);
`endif

    // all-zero window
    put(32'h0, 16); p0 = ptr;
    run_elem(1'b0, lat);
    cmp("t5_lat", lat, 2); cmp("t5_err", done_err, 1); cmp("t5_val", done_val, 0); cmp("t5_adv", ptr - p0, 16);

    // 3-cycle SUFFIX stall with start pulsed while busy
    put(32'b00110, 5);
    done_cyc = -1;
    start = 1'b1; se_mode = 1'b0; buffer_valid = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    buffer_valid = 1'b0; start = 1'b1;
    repeat (3) tick();
    start = 1'b0; buffer_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (done_cyc >= 0) break;
      tick();
    end
    cmp("t6_lat", done_cyc - accept_cyc, 7); cmp("t6_val", done_val, 5);
    tick();
    cmp("t6_idle", busy, 0);

    // reset asserted in WAIT_PFX
    put(32'b00110, 5);
    start = 1'b1; se_mode = 1'b0;
    tick();
    start = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    cmp("rst_busy", busy, 0); cmp("rst_hoe", heading_one_en, 1); cmp("rst_req", shift_req, 0);
    cmp("rst_len", shift_len, 0); cmp("rst_done", done, 0); cmp("rst_err", error, 0); cmp("rst_val", value, 0);
    m_busy = 0; detecting = 0; wait_one = 0; sfx = 0; done_now = 0; last_val = 0; q_shift.delete();
    repeat (3) tick();
    reset_n = 1'b1;
    put(32'b00100, 5);
    run_elem(1'b0, lat);
    cmp("t7_lat", lat, 4); cmp("t7_val", done_val, 3);

    // MAX_PREFIX = 8 instance, L = 9
    win8 = 16'h0040; pos8 = 4'd9; valid8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(negedge clk);
    cmp("m8_req", req8, 1); cmp("m8_len", len8, 10); cmp("m8_hoe", hoe8, 0);
    @(negedge clk);
    cmp("m8_done", done8, 1); cmp("m8_err", err8, 1); cmp("m8_val", value8, 0);
    @(posedge clk); #1;

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 2) == 0);
      se_mode = 1'($urandom);
      buffer_valid = ($urandom_range(0, 3) != 0);
      tick();
    end
    start = 1'b0; buffer_valid = 1'b1;
    repeat (30) tick();
    cmp("drain_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
